// File: rtl/decode_inst_queue.sv
// decode_inst_queue: compacts sparse fetch bundles into an in-order FIFO and presents the oldest packets to decode.
// Optional macro INSTQ_PERF_CNT_EN adds full_cycles_o, a saturating count of cycles spent back-pressuring fetch.
`ifndef DEC_PKT_SIZE
`define DEC_PKT_SIZE 32
`endif

module decode_inst_queue #(
    parameter int FETCH_WIDTH    = 4,
    parameter int DISPATCH_WIDTH = 4,
    parameter int DEPTH          = 16,
    parameter int PKT_W          = `DEC_PKT_SIZE
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            flush_i,
    input  logic [FETCH_WIDTH*PKT_W-1:0]    pkt_i,
    input  logic [FETCH_WIDTH-1:0]          valid_i,
    input  logic                            stall_i,
    output logic [DISPATCH_WIDTH*PKT_W-1:0] pkt_o,
    output logic [DISPATCH_WIDTH-1:0]       valid_o,
    output logic                            stall_o,
    output logic [$clog2(DEPTH):0]          count_o
`ifdef INSTQ_PERF_CNT_EN
    ,
    output logic [31:0]                     full_cycles_o
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PKT_W-1:0] storage [DEPTH];
    logic [PTR_W-1:0] head, tail;
    logic [CNT_W-1:0] count, count_next;
    logic [CNT_W-1:0] npush, npop;
    logic [PTR_W-1:0] lane_off [FETCH_WIDTH];
    logic             push_en, pop_en;

    // Each valid lane lands at tail + (number of valid lanes below it).
    always_comb begin
        npush = '0;
        for (int k = 0; k < FETCH_WIDTH; k++) begin
            lane_off[k] = npush[PTR_W-1:0];
            npush       = npush + CNT_W'(valid_i[k]);
        end
    end

    // Stall looks only at the registered count; a same-cycle pop is not credited.
    assign stall_o    = (CNT_W'(DEPTH) - count) < CNT_W'(FETCH_WIDTH);
    assign push_en    = ~stall_o & ~flush_i;
    assign pop_en     = ~stall_i & ~flush_i;
    assign npop       = (count < CNT_W'(DISPATCH_WIDTH)) ? count : CNT_W'(DISPATCH_WIDTH);
    assign count_next = count + (push_en ? npush : '0) - (pop_en ? npop : '0);
    assign count_o    = count;

    always_ff @(posedge clk) begin
        if (reset || flush_i) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push_en) tail <= tail + npush[PTR_W-1:0];
            if (pop_en)  head <= head + npop[PTR_W-1:0];
            count <= count_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) storage[i] <= '0;
        end else if (push_en) begin
            for (int k = 0; k < FETCH_WIDTH; k++) begin
                if (valid_i[k]) storage[tail + lane_off[k]] <= pkt_i[k*PKT_W +: PKT_W];
            end
        end
    end

    always_comb begin
        pkt_o   = '0;
        valid_o = '0;
        for (int k = 0; k < DISPATCH_WIDTH; k++) begin
            pkt_o[k*PKT_W +: PKT_W] = storage[head + PTR_W'(k)];
            valid_o[k]              = CNT_W'(k) < count;
        end
    end

`ifdef INSTQ_PERF_CNT_EN
    logic [31:0] full_cycles;

    // Flush does not clear the counter; only reset does.
    always_ff @(posedge clk) begin
        if (reset) begin
            full_cycles <= '0;
        end else if (stall_o && !flush_i && full_cycles != 32'hFFFF_FFFF) begin
            full_cycles <= full_cycles + 32'd1;
        end
    end

    assign full_cycles_o = full_cycles;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (count <= CNT_W'(DEPTH));
            assert (npop <= count);
        end
    end

endmodule

// File: tb/tb_decode_inst_queue.sv
// Bench for decode_inst_queue: table-driven vectors plus a queue scoreboard of expected packets.
// Build with INSTQ_PERF_CNT_EN defined to also exercise full_cycles_o.
`ifndef DEC_PKT_SIZE
`define DEC_PKT_SIZE 32
`endif

module tb_decode_inst_queue;

    localparam int FW    = 4;
    localparam int DW    = 4;
    localparam int DEPTH = 16;
    localparam int PKT_W = `DEC_PKT_SIZE;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               flush_i = 1'b0;
    logic [FW*PKT_W-1:0] pkt_i = '0;
    logic [FW-1:0]      valid_i = '0;
    logic               stall_i = 1'b1;
    logic [DW*PKT_W-1:0] pkt_o;
    logic [DW-1:0]      valid_o;
    logic               stall_o;
    logic [$clog2(DEPTH):0] count_o;
`ifdef INSTQ_PERF_CNT_EN
    logic [31:0]        full_cycles_o;
`endif

    always #5 clk = ~clk;

    decode_inst_queue #(
        .FETCH_WIDTH(FW), .DISPATCH_WIDTH(DW), .DEPTH(DEPTH), .PKT_W(PKT_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .flush_i(flush_i),
        .pkt_i(pkt_i),
        .valid_i(valid_i),
        .stall_i(stall_i),
        .pkt_o(pkt_o),
        .valid_o(valid_o),
        .stall_o(stall_o),
        .count_o(count_o)
`ifdef INSTQ_PERF_CNT_EN
        ,
        .full_cycles_o(full_cycles_o)
`endif
    );

    typedef struct {
        logic [FW-1:0] v;
        logic          st;
        logic          fl;
        int            exp_cnt;
        logic [DW-1:0] exp_vo;
        logic          exp_stall;
    } vec_t;

    logic [PKT_W-1:0] exp_q[$];
    logic [PKT_W-1:0] got_q[$];
    int  n_tests = 0;
    int  n_fail  = 0;
    bit  collect = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [FW*PKT_W-1:0] mk_bundle(input int base, input int seq);
        logic [FW*PKT_W-1:0] b;
        for (int k = 0; k < FW; k++) b[k*PKT_W +: PKT_W] = PKT_W'(base + seq * 4 + k);
        return b;
    endfunction

    function automatic logic [PKT_W-1:0] lane_of(input logic [DW*PKT_W-1:0] bus, input int k);
        return bus[k*PKT_W +: PKT_W];
    endfunction

    // Check current outputs against the model, drive one cycle, then advance the model.
    task automatic step(input logic [FW-1:0] v, input logic [FW*PKT_W-1:0] pk,
                        input logic st, input logic fl);
        int            n;
        int            nvis;
        bit            stall_exp;
        logic [DW-1:0] vmask;
        n         = exp_q.size();
        nvis      = (n < DW) ? n : DW;
        stall_exp = (DEPTH - n) < FW;
        vmask     = '0;
        for (int k = 0; k < nvis; k++) vmask[k] = 1'b1;
        chk("count_o", 64'(count_o), 64'(n));
        chk("stall_o", 64'(stall_o), 64'(stall_exp));
        chk("valid_o", 64'(valid_o), 64'(vmask));
        for (int k = 0; k < nvis; k++) chk("pkt_o lane", 64'(lane_of(pkt_o, k)), 64'(exp_q[k]));
        if (collect && !st && !fl)
            for (int k = 0; k < nvis; k++) got_q.push_back(lane_of(pkt_o, k));
        valid_i = v;
        pkt_i   = pk;
        stall_i = st;
        flush_i = fl;
        @(posedge clk);
        #1;
        if (fl) begin
            exp_q.delete();
        end else begin
            if (!st) repeat (nvis) void'(exp_q.pop_front());
            if (!stall_exp)
                for (int k = 0; k < FW; k++) if (v[k]) exp_q.push_back(pk[k*PKT_W +: PKT_W]);
        end
        valid_i = '0;
        flush_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        valid_i = '0;
        flush_i = 1'b0;
        stall_i = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        @(negedge clk);
    endtask

    vec_t tbl[9];

    initial begin
        tbl[0] = '{4'b1111, 1'b1, 1'b0, 4,  4'b1111, 1'b0};
        tbl[1] = '{4'b1111, 1'b1, 1'b0, 8,  4'b1111, 1'b0};
        tbl[2] = '{4'b1111, 1'b1, 1'b0, 12, 4'b1111, 1'b0};
        tbl[3] = '{4'b1111, 1'b1, 1'b0, 16, 4'b1111, 1'b1};
        tbl[4] = '{4'b1111, 1'b1, 1'b0, 16, 4'b1111, 1'b1};
        tbl[5] = '{4'b0000, 1'b0, 1'b0, 12, 4'b1111, 1'b0};
        tbl[6] = '{4'b1111, 1'b0, 1'b1, 0,  4'b0000, 1'b0};
        tbl[7] = '{4'b1010, 1'b1, 1'b0, 2,  4'b0011, 1'b0};
        tbl[8] = '{4'b0000, 1'b0, 1'b0, 0,  4'b0000, 1'b0};

        do_reset();
        chk("reset count_o", 64'(count_o), 64'd0);
        chk("reset valid_o", 64'(valid_o), 64'd0);
        chk("reset stall_o", 64'(stall_o), 64'd0);
        for (int k = 0; k < DW; k++) chk("reset pkt_o", 64'(lane_of(pkt_o, k)), 64'd0);

        // Fill, overflow attempt, pop, flush, sparse bundle, drain.
        for (int i = 0; i < 9; i++) begin
            step(tbl[i].v, mk_bundle('hA00, i), tbl[i].st, tbl[i].fl);
            chk("tbl count_o", 64'(count_o), 64'(tbl[i].exp_cnt));
            chk("tbl valid_o", 64'(valid_o), 64'(tbl[i].exp_vo));
            chk("tbl stall_o", 64'(stall_o), 64'(tbl[i].exp_stall));
            if (i == 0)
                for (int k = 0; k < DW; k++)
                    chk("A lanes", 64'(lane_of(pkt_o, k)), 64'('hA00 + k));
            if (i == 7) begin
                chk("B1 at lane0", 64'(lane_of(pkt_o, 0)), 64'('hA00 + 7 * 4 + 1));
                chk("B3 at lane1", 64'(lane_of(pkt_o, 1)), 64'('hA00 + 7 * 4 + 3));
            end
        end

        // Streaming across pointer wrap: tags 0..39 must pop in order.
        do_reset();
        collect = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(4'b1111, mk_bundle(0, i), 1'b0, 1'b0);
            chk("stream count_o", 64'(count_o), 64'd4);
        end
        step(4'b0000, '0, 1'b0, 1'b0);
        collect = 1'b0;
        chk("stream length", 64'(got_q.size()), 64'd40);
        for (int i = 0; i < got_q.size(); i++) chk("stream order", 64'(got_q[i]), 64'(i));

        // Flush at count 9 with a simultaneous push and pop request.
        do_reset();
        step(4'b1111, mk_bundle('h500, 0), 1'b1, 1'b0);
        step(4'b1111, mk_bundle('h500, 1), 1'b1, 1'b0);
        step(4'b0001, mk_bundle('h500, 2), 1'b1, 1'b0);
        chk("pre-flush count_o", 64'(count_o), 64'd9);
        step(4'b1111, mk_bundle('h500, 3), 1'b0, 1'b1);
        chk("flush count_o", 64'(count_o), 64'd0);
        chk("flush valid_o", 64'(valid_o), 64'd0);
        chk("flush stall_o", 64'(stall_o), 64'd0);
        step(4'b0001, mk_bundle('hC00, 0), 1'b1, 1'b0);
        chk("C0 at lane0", 64'(lane_of(pkt_o, 0)), 64'('hC00));
        chk("C0 valid_o", 64'(valid_o), 64'b0001);
        step(4'b0000, '0, 1'b1, 1'b0);

        // Reset in the middle of traffic clears pointers and storage.
        step(4'b1111, mk_bundle('h700, 0), 1'b1, 1'b0);
        do_reset();
        chk("mid-reset count_o", 64'(count_o), 64'd0);
        chk("mid-reset valid_o", 64'(valid_o), 64'd0);
        chk("mid-reset lane0", 64'(lane_of(pkt_o, 0)), 64'd0);
        step(4'b0000, '0, 1'b1, 1'b0);

`ifdef INSTQ_PERF_CNT_EN
        do_reset();
        for (int i = 0; i < 4; i++) step(4'b1111, mk_bundle('h900, i), 1'b1, 1'b0);
        chk("perf full stall_o", 64'(stall_o), 64'd1);
        chk("perf start", 64'(full_cycles_o), 64'd0);
        for (int i = 0; i < 5; i++) step(4'b0000, '0, 1'b1, 1'b0);
        chk("perf held 5", 64'(full_cycles_o), 64'd5);
        step(4'b0000, '0, 1'b1, 1'b1);
        chk("perf after flush", 64'(full_cycles_o), 64'd5);
        do_reset();
        chk("perf after reset", 64'(full_cycles_o), 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
